data_controller: RTL and testbench
==================================

DATA_CONTROLLER -- requirements
Module: data_controller

Interface
REQ-001 Parameter DATA_W, 32: width of one feature-map memory word.
REQ-002 Parameter PRELOAD, 4: words fetched per prepare phase; legal range 3..15.
REQ-003 Parameter ADDR_W, 16: memory address width.
REQ-004 clk  in  1  clock, all flops rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 block_width_i  in  8  tile columns for the current pass.
REQ-007 block_height_i  in  8  tile rows for the current pass.
REQ-008 data_id_i  in  4  input-depth slice index for the current pass.
REQ-009 data_prepare_i  in  1  request to load the slice and parameters.
REQ-010 data_start_i  in  1  request to stream tiles; level signal.
REQ-011 data_ready_o  out  1  preload finished, waiting for start.
REQ-012 data_complete_o  out  1  all tiles of the pass accepted.
REQ-013 mem_ren_o  out  1  memory read enable.
REQ-014 mem_addr_o  out  ADDR_W  memory read address.
REQ-015 mem_rdata_i  in  DATA_W  read data, valid exactly 1 cycle after mem_ren_o.
REQ-016 tile_valid_o  out  1  tile descriptor valid.
REQ-017 tile_ready_i  in  1  downstream accepts the descriptor.
REQ-018 tile_row_o  out  8  current tile row.
REQ-019 tile_col_o  out  8  current tile column.
REQ-020 tile_data_o  out  DATA_W  buffer word for the current tile.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, READY, STREAM, DONE.
REQ-022 IDLE: data_prepare_i=1 -> latch width, height, id; go LOAD next cycle.
REQ-023 Latched width or height of 0 SHALL be stored as 1.
REQ-024 LOAD: mem_ren_o=1 for PRELOAD consecutive cycles; address k = {data_id latched, zeros} + k, k=0..PRELOAD-1, id occupying mem_addr_o[ADDR_W-1:ADDR_W-4].
REQ-025 LOAD: mem_rdata_i captured into buffer[k] the cycle after read k; enter READY the cycle after the last capture (LOAD lasts PRELOAD+1 cycles).
REQ-026 READY: data_ready_o=1; enter STREAM on rising edge of data_start_i (data_start_i=1 and its registered previous value=0); a level held high from before READY SHALL NOT trigger.
REQ-027 STREAM: tile_valid_o=1; row/col start 0,0; advance only when tile_valid_o & tile_ready_i; col increments, wraps to 0 at width-1 with row increment.
REQ-028 tile_data_o SHALL equal buffer[(row*width+col) mod PRELOAD]; row/col/data held stable while tile_ready_i=0.
REQ-029 Acceptance of tile (height-1, width-1) -> DONE next cycle; tile_valid_o low in DONE.
REQ-030 DONE: data_complete_o=1 held until data_prepare_i=1, which relatches parameters and enters LOAD next cycle; data_start_i ignored in DONE.
REQ-031 data_prepare_i ignored in LOAD, READY, STREAM.
REQ-032 Outputs not listed active for a state SHALL be 0 (addr 0, row/col 0, data 0).

Reset
REQ-033 reset=1 SHALL immediately force IDLE, all outputs 0, buffer, counters, latched parameters and start-edge register 0, including mid-LOAD or mid-STREAM.
REQ-034 After reset release, no memory read or tile SHALL issue until data_prepare_i=1.

Verification
REQ-035 id=3, width=2, height=2, prepare pulse -> mem_ren 4 cycles, addr 0x3000..0x3003, data_ready after 5 LOAD cycles.
REQ-036 From READY, start rising, tile_ready_i=1 -> tiles (0,0),(0,1),(1,0),(1,1) on 4 consecutive cycles, tile_data = buf[0..3], then data_complete_o=1.
REQ-037 width=3, height=1, tile_ready_i toggling 1,0,1,0,1 -> 3 tiles accepted, descriptors stable while stalled, complete after 3rd accept.
REQ-038 width=0, height=0 -> exactly one tile (0,0) then DONE.
REQ-039 data_start_i held high from before READY -> no STREAM until start goes low then high.
REQ-040 reset asserted on 2nd STREAM tile -> all outputs 0 same cycle; after release, IDLE with no activity until prepare.

Source files
------------

// File: rtl/data_controller.sv
// data_controller: preloads a feature-map slice into a small buffer, then streams tile descriptors.
module data_controller #(
  parameter int DATA_W  = 32,
  parameter int PRELOAD = 4,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        block_width_i,
  input  logic [7:0]        block_height_i,
  input  logic [3:0]        data_id_i,
  input  logic              data_prepare_i,
  input  logic              data_start_i,
  output logic              data_ready_o,
  output logic              data_complete_o,
  output logic              mem_ren_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              tile_valid_o,
  input  logic              tile_ready_i,
  output logic [7:0]        tile_row_o,
  output logic [7:0]        tile_col_o,
  output logic [DATA_W-1:0] tile_data_o
);
  localparam logic [3:0] PL = 4'(PRELOAD);
  typedef enum logic [2:0] {IDLE, LOAD, READY, STREAM, DONE} state_t;
  state_t state, state_n;
  logic [7:0] w_q, h_q, row_q, col_q;
  logic [3:0] id_q, k_q, idx_q;
  logic start_q, latch, accept, last_col, last_tile;
  logic [DATA_W-1:0] buf_q [16];
  always_comb begin
    latch     = (state == IDLE || state == DONE) && data_prepare_i;
    accept    = state == STREAM && tile_ready_i;
    last_col  = col_q == w_q - 8'd1;
    last_tile = last_col && row_q == h_q - 8'd1;
    state_n   = state;
    case (state)
      IDLE, DONE: state_n = data_prepare_i ? LOAD : state;
      LOAD:       state_n = k_q == PL ? READY : LOAD;
      READY:      state_n = data_start_i && !start_q ? STREAM : READY;
      STREAM:     state_n = accept && last_tile ? DONE : STREAM;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // k_q walks reads 0..PRELOAD-1; capture of read k lands one cycle later at buf[k_q-1]
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {w_q, h_q, row_q, col_q, id_q, k_q, idx_q, start_q} <= '0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else begin
      start_q <= data_start_i;
      if (latch) begin
        w_q  <= block_width_i == 8'd0 ? 8'd1 : block_width_i;
        h_q  <= block_height_i == 8'd0 ? 8'd1 : block_height_i;
        id_q <= data_id_i;
        k_q  <= '0;
      end
      if (state == LOAD && k_q != PL) k_q <= k_q + 4'd1;
      if (state == LOAD && k_q != 4'd0) buf_q[k_q-4'd1] <= mem_rdata_i;
      if (accept) begin
        col_q <= last_col ? 8'd0 : col_q + 8'd1;
        row_q <= last_tile ? 8'd0 : last_col ? row_q + 8'd1 : row_q;
        idx_q <= last_tile || idx_q == PL - 4'd1 ? 4'd0 : idx_q + 4'd1;
      end
    end
  assign data_ready_o    = state == READY;
  assign data_complete_o = state == DONE;
  assign mem_ren_o       = state == LOAD && k_q < PL;
  assign mem_addr_o      = mem_ren_o ? {id_q, {(ADDR_W-4){1'b0}}} + ADDR_W'(k_q) : '0;
  assign tile_valid_o    = state == STREAM;
  assign tile_row_o      = tile_valid_o ? row_q : '0;
  assign tile_col_o      = tile_valid_o ? col_q : '0;
  assign tile_data_o     = tile_valid_o ? buf_q[idx_q] : '0;
endmodule

// File: tb/tb_data_controller.sv
// tb_data_controller: scoreboard bench; memory model answers reads, expected reads/tiles queued per pass.
module tb_data_controller;
  localparam int DW = 32, PL = 4, AW = 16;
  logic clk = 0, reset = 1;
  logic [7:0] block_width_i = 0, block_height_i = 0;
  logic [3:0] data_id_i = 0;
  logic data_prepare_i = 0, data_start_i = 0, tile_ready_i = 0;
  logic data_ready_o, data_complete_o, mem_ren_o, tile_valid_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_rdata_i = '0, tile_data_o;
  logic [7:0] tile_row_o, tile_col_o;
  logic [8+8+DW-1:0] cur, held;
  logic stall_prev = 0;
  int n_vec = 0, n_err = 0, rd_cnt = 0, acc_cnt = 0;
  logic [AW-1:0] exp_addr_q [$];
  logic [8+8+DW-1:0] exp_tile_q [$];

  data_controller #(.DATA_W(DW), .PRELOAD(PL), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .block_width_i(block_width_i), .block_height_i(block_height_i),
    .data_id_i(data_id_i), .data_prepare_i(data_prepare_i), .data_start_i(data_start_i),
    .data_ready_o(data_ready_o), .data_complete_o(data_complete_o), .mem_ren_o(mem_ren_o),
    .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .tile_valid_o(tile_valid_o),
    .tile_ready_i(tile_ready_i), .tile_row_o(tile_row_o), .tile_col_o(tile_col_o),
    .tile_data_o(tile_data_o)
  );

  always #5 clk = ~clk;
  assign cur = {tile_row_o, tile_col_o, tile_data_o};

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return {a ^ 16'hc3c3, a};
  endfunction

  always @(posedge clk) mem_rdata_i <= mem_ren_o ? word_at(mem_addr_o) : 32'hdead_beef;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) stall_prev = 0;
    else begin
      if (mem_ren_o) begin
        rd_cnt++;
        if (exp_addr_q.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_addr", 64'(mem_addr_o), 64'(exp_addr_q.pop_front()));
      end
      if (stall_prev && tile_valid_o) check("stall_hold", 64'(cur), 64'(held));
      if (tile_valid_o && tile_ready_i) begin
        acc_cnt++;
        if (exp_tile_q.size() == 0) check("tile_unexpected", 1, 0);
        else check("tile", 64'(cur), 64'(exp_tile_q.pop_front()));
      end
      stall_prev = tile_valid_o && !tile_ready_i;
      held = cur;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({data_ready_o, data_complete_o, mem_ren_o, tile_valid_o}), 0);
    check({tag, "_addr"}, 64'(mem_addr_o), 0);
    check({tag, "_rowcol"}, 64'({tile_row_o, tile_col_o}), 0);
    check({tag, "_data"}, 64'(tile_data_o), 0);
  endtask

  task automatic prepare(input logic [3:0] id, input logic [7:0] w, input logic [7:0] h);
    int we = w == 0 ? 1 : int'(w);
    int he = h == 0 ? 1 : int'(h);
    int n = 0;
    int r0 = rd_cnt;
    logic [AW-1:0] base = {id, 12'h000};
    for (int k = 0; k < PL; k++) exp_addr_q.push_back(base + 16'(k));
    for (int r = 0; r < he; r++)
      for (int c = 0; c < we; c++)
        exp_tile_q.push_back({8'(r), 8'(c), word_at(base + 16'((r * we + c) % PL))});
    @(posedge clk); #1;
    data_id_i = id; block_width_i = w; block_height_i = h; data_prepare_i = 1;
    @(posedge clk); #1;
    data_prepare_i = 0; data_id_i = 0; block_width_i = 8'hee; block_height_i = 8'hee;
    while (!data_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_latency", 64'(n), 64'(PL + 2));
    check("rd_count", 64'(rd_cnt - r0), 64'(PL));
    check("rd_drained", 64'(exp_addr_q.size()), 0);
  endtask

  task automatic run_stream(input logic [7:0] pat, input int plen, output int cyc);
    int p = 0;
    cyc = 0;
    @(posedge clk); #1;
    data_start_i = 1;
    while (cyc < 100) begin
      tile_ready_i = tile_valid_o ? pat[p % plen] : 1'b0;
      if (tile_valid_o) p++;
      @(negedge clk);
      cyc++;
      if (data_complete_o) break;
      @(posedge clk); #1;
    end
    data_start_i = 0;
    tile_ready_i = 0;
    check("complete", 64'(data_complete_o), 1);
    check("valid_done", 64'(tile_valid_o), 0);
    check("tiles_drained", 64'(exp_tile_q.size()), 0);
  endtask

  initial begin
    int cyc, a0, r0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    #1 reset = 0;
    repeat (5) @(negedge clk);
    check_zero("idle");
    check("idle_quiet", 64'(rd_cnt + acc_cnt), 0);
    // 2x2 pass, continuous acceptance
    prepare(4'd3, 8'd2, 8'd2);
    a0 = acc_cnt;
    run_stream(8'hff, 1, cyc);
    check("t1_cycles", 64'(cyc), 6);
    check("t1_accepts", 64'(acc_cnt - a0), 4);
    @(posedge clk); #1 data_start_i = 1;
    repeat (3) @(negedge clk);
    check("done_ignores_start", 64'({data_complete_o, tile_valid_o}), 64'(2'b10));
    data_start_i = 0;
    // 3x1 pass with stalls; prepare from DONE
    prepare(4'd1, 8'd3, 8'd1);
    a0 = acc_cnt;
    run_stream(8'b0001_0101, 5, cyc);
    check("t2_cycles", 64'(cyc), 7);
    check("t2_accepts", 64'(acc_cnt - a0), 3);
    // zero dimensions act as 1x1
    prepare(4'ha, 8'd0, 8'd0);
    a0 = acc_cnt;
    run_stream(8'hff, 1, cyc);
    check("t3_cycles", 64'(cyc), 3);
    check("t3_accepts", 64'(acc_cnt - a0), 1);
    // start held high across READY entry; prepare ignored in READY
    @(posedge clk); #1 data_start_i = 1;
    prepare(4'd5, 8'd2, 8'd1);
    r0 = rd_cnt;
    @(posedge clk); #1 data_prepare_i = 1;
    @(posedge clk); #1 data_prepare_i = 0;
    repeat (4) @(negedge clk);
    check("held_start_ready", 64'({data_ready_o, tile_valid_o}), 64'(2'b10));
    check("prepare_ignored", 64'(rd_cnt - r0), 0);
    data_start_i = 0;
    run_stream(8'hff, 1, cyc);
    check("t4_cycles", 64'(cyc), 4);
    // reset during the second tile
    prepare(4'd2, 8'd2, 8'd2);
    @(posedge clk); #1;
    data_start_i = 1;
    tile_ready_i = 1;
    repeat (3) @(negedge clk);
    #1 check("t5_second_tile", 64'({tile_valid_o, tile_row_o, tile_col_o}), 64'({1'b1, 8'd0, 8'd1}));
    reset = 1;
    #1 check_zero("async_reset");
    exp_tile_q.delete();
    data_start_i = 0;
    tile_ready_i = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    r0 = rd_cnt;
    a0 = acc_cnt;
    repeat (6) @(negedge clk);
    check_zero("post_reset");
    check("post_reset_quiet", 64'((rd_cnt - r0) + (acc_cnt - a0)), 0);
    prepare(4'd4, 8'd1, 8'd1);
    run_stream(8'hff, 1, cyc);
    check("t6_cycles", 64'(cyc), 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
